// File: rtl/opa_phase_bank.sv
// Ping-pong phase memory: the host fills the shadow bank while the active bank
// is streamed out over a valid/ready interface; commit swaps the banks atomically.
module opa_phase_bank #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_CH     = 512
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  commit,
    input  logic                  start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  active_bank,
    output logic                  commit_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_CH - 1);
    localparam logic [ADDR_WIDTH:0]   NUM_CH_EXT = (ADDR_WIDTH + 1)'(NUM_CH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_reg, state_next;
    logic   pending_reg, pending_next;
    logic   active_bank_reg;
    logic   commit_done_reg;
    logic   swap;
    logic   start_scan;

    logic [ADDR_WIDTH-1:0] scan_addr_reg;
    logic                  scan_run_reg;
    logic                  issue;

    logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  s1_valid_reg;
    logic [ADDR_WIDTH-1:0] s1_addr_reg;
    logic                  s1_last;

    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic                  out_last_reg;
    logic                  skid_valid_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;
    logic [ADDR_WIDTH-1:0] skid_addr_reg;
    logic                  skid_last_reg;

    logic       accept;
    logic       last_accept;
    logic [1:0] fill;
    logic       wr_ok;

    assign accept      = out_valid_reg && out_ready;
    assign last_accept = accept && out_last_reg;
    assign wr_ok       = wr_en && ({1'b0, wr_addr} < NUM_CH_EXT);
    assign s1_last     = (s1_addr_reg == LAST_ADDR);

    // Entries that will sit in out/skid after this edge; a new read may only be
    // issued if its word is guaranteed a slot even if the consumer stalls next cycle.
    assign fill  = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg}
                 + {1'b0, s1_valid_reg} - {1'b0, accept};
    assign issue = (state_reg == STREAM) && scan_run_reg && (fill <= 2'd1);

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        swap         = 1'b0;
        start_scan   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (commit || pending_reg) begin
                    swap         = 1'b1;
                    pending_next = 1'b0;
                end
                if (start) begin
                    state_next = STREAM;
                    start_scan = 1'b1;
                end
            end
            STREAM: begin
                if (last_accept) begin
                    state_next   = IDLE;
                    swap         = commit || pending_reg;
                    pending_next = 1'b0;
                end else if (commit) begin
                    pending_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            pending_reg     <= 1'b0;
            active_bank_reg <= 1'b0;
            commit_done_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            active_bank_reg <= active_bank_reg ^ swap;
            commit_done_reg <= swap;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_run_reg  <= 1'b0;
            scan_addr_reg <= '0;
            s1_valid_reg  <= 1'b0;
            s1_addr_reg   <= '0;
        end else begin
            s1_valid_reg <= issue;
            if (issue) begin
                s1_addr_reg <= scan_addr_reg;
            end
            if (start_scan) begin
                scan_run_reg  <= 1'b1;
                scan_addr_reg <= '0;
            end else if (issue) begin
                if (scan_addr_reg == LAST_ADDR) begin
                    scan_run_reg <= 1'b0;
                end else begin
                    scan_addr_reg <= scan_addr_reg + 1'b1;
                end
            end
        end
    end

    // Writes use the pre-edge bank, so a write coinciding with a swap lands in
    // the bank that becomes active. Both banks share one array indexed {bank, addr}.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[{~active_bank_reg, wr_addr}] <= wr_data;
        end
        rd_data_reg <= mem[{active_bank_reg, scan_addr_reg}];
    end

    // Output register is the head of a two-entry queue; the skid entry catches
    // the word already in flight from the RAM when the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_addr_reg   <= '0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_addr_reg  <= '0;
            skid_last_reg  <= 1'b0;
        end else if (!out_valid_reg || accept) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= skid_data_reg;
                out_addr_reg   <= skid_addr_reg;
                out_last_reg   <= skid_last_reg;
                skid_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    skid_data_reg <= rd_data_reg;
                    skid_addr_reg <= s1_addr_reg;
                    skid_last_reg <= s1_last;
                end
            end else begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= rd_data_reg;
                    out_addr_reg <= s1_addr_reg;
                    out_last_reg <= s1_last;
                end
            end
        end else if (s1_valid_reg) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= rd_data_reg;
            skid_addr_reg  <= s1_addr_reg;
            skid_last_reg  <= s1_last;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_addr    = out_addr_reg;
    assign out_last    = out_last_reg;
    assign busy        = (state_reg == STREAM);
    assign active_bank = active_bank_reg;
    assign commit_done = commit_done_reg;

endmodule

// File: tb/tb_opa_phase_bank.sv
// Self-checking bench for opa_phase_bank: directed frames plus random traffic,
// scored against a bank/queue model of the ping-pong memory.
module tb_opa_phase_bank;

    localparam int DW  = 24;
    localparam int AW  = 4;
    localparam int NCH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          active_bank;
    logic          commit_done;

    always #5 clock = ~clock;

    opa_phase_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .start(start),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy),
        .active_bank(active_bank), .commit_done(commit_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cd_count = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic          in_start;
        logic          in_ready;
        logic          exp_valid;
        logic          exp_busy;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_addr;
        logic          exp_last;
    } vec_t;

    // Reference model: two banks of words, which one is live, and the frame
    // snapshot still owed to the consumer.
    logic [DW-1:0] m_bank [2][NCH];
    logic          m_act = 1'b0;
    logic          m_pend = 1'b0;
    logic          m_stream = 1'b0;
    logic          m_cd = 1'b0;
    beat_t         exp_q[$];
    logic [DW-1:0] acc_log[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic cycle();
        logic          acc, swap, frame_end, hold_v, hold_l;
        logic [DW-1:0] hold_d;
        logic [AW-1:0] hold_a;
        beat_t         b;
        acc       = out_valid && out_ready;
        hold_v    = out_valid && !out_ready && !reset;
        hold_d    = out_data;
        hold_a    = out_addr;
        hold_l    = out_last;
        swap      = 1'b0;
        frame_end = 1'b0;
        if (reset) begin
            m_act = 1'b0; m_pend = 1'b0; m_stream = 1'b0;
            exp_q.delete();
        end else begin
            if (acc) begin
                acc_log.push_back(out_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_addr), 32'hFFFF);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_addr", 32'(out_addr), 32'(b.addr));
                    check("beat_data", 32'(out_data), 32'(b.data));
                    check("beat_last", 32'(out_last), 32'(b.addr == AW'(NCH - 1)));
                    frame_end = (exp_q.size() == 0);
                end
            end
            if (wr_en && int'(wr_addr) < NCH) m_bank[~m_act][wr_addr] = wr_data;
            if (!m_stream) begin
                swap = commit || m_pend;
                m_pend = 1'b0;
                if (swap) m_act = ~m_act;
                if (start) begin
                    m_stream = 1'b1;
                    for (int k = 0; k < NCH; k++) begin
                        b.addr = AW'(k);
                        b.data = m_bank[m_act][k];
                        exp_q.push_back(b);
                    end
                end
            end else if (frame_end) begin
                m_stream = 1'b0;
                swap = commit || m_pend;
                m_pend = 1'b0;
                if (swap) m_act = ~m_act;
            end else if (commit) begin
                m_pend = 1'b1;
            end
        end
        m_cd = swap;
        @(posedge clock);
        #1;
        if (commit_done) cd_count++;
        check("commit_done", 32'(commit_done), 32'(m_cd));
        check("active_bank", 32'(active_bank), 32'(m_act));
        check("busy", 32'(busy), 32'(m_stream));
        if (!m_stream) check("idle_valid", 32'(out_valid), 0);
        if (hold_v) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(hold_d));
            check("hold_addr", 32'(out_addr), 32'(hold_a));
            check("hold_last", 32'(out_last), 32'(hold_l));
        end
    endtask

    function automatic logic ready_for(input int mode, input int i);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[i % 4];
            default: return ($urandom_range(0, 9) < 7);
        endcase
    endfunction

    task automatic run_frame(input int mode, input logic with_commit, input logic mid_updates);
        acc_log.delete();
        start = 1'b1;
        commit = with_commit;
        out_ready = ready_for(mode, 0);
        cycle();
        start = 1'b0;
        commit = 1'b0;
        for (int i = 0; i < 400 && m_stream; i++) begin
            out_ready = ready_for(mode, i + 1);
            if (mid_updates && i < NCH) begin
                wr_en = 1'b1;
                wr_addr = AW'(i);
                wr_data = DW'(32'h200 + i);
            end
            commit = mid_updates && (i == 2 || i == 5);
            cycle();
            wr_en = 1'b0;
            commit = 1'b0;
        end
        check("frame_timeout_busy", 32'(busy), 0);
        out_ready = 1'b0;
    endtask

    task automatic fill_shadow(input logic [31:0] base);
        for (int k = 0; k < NCH; k++) begin
            wr_en = 1'b1;
            wr_addr = AW'(k);
            wr_data = DW'(base + 32'(k));
            cycle();
        end
        wr_en = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [31:0] base);
        check({name, "_count"}, 32'(acc_log.size()), NCH);
        for (int k = 0; k < NCH && k < acc_log.size(); k++)
            check(name, 32'(acc_log[k]), base + 32'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        int   cd_before;
        logic found;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 1'b0};
        for (int k = 0; k < NCH; k++)
            tbl[k + 2] = '{1'b0, 1'b1, 1'b1, 1'b1, DW'(32'h100 + k), AW'(k), (k == NCH - 1)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0};

        // Reset state
        reset = 1'b1;
        cycle();
        cycle();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_bank", 32'(active_bank), 0);
        reset = 1'b0;
        cycle();

        // Test 1: load shadow, commit, stream with the cycle-by-cycle table
        fill_shadow(32'h100);
        cd_before = cd_count;
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        cycle();
        check("t1_commit_pulses", 32'(cd_count - cd_before), 1);
        check("t1_bank", 32'(active_bank), 1);
        acc_log.delete();
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].in_start;
            out_ready = tbl[i].in_ready;
            cycle();
            check($sformatf("t1_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].exp_busy));
            if (tbl[i].exp_valid) begin
                check($sformatf("t1_data[%0d]", i), 32'(out_data), 32'(tbl[i].exp_data));
                check($sformatf("t1_addr[%0d]", i), 32'(out_addr), 32'(tbl[i].exp_addr));
                check($sformatf("t1_last[%0d]", i), 32'(out_last), 32'(tbl[i].exp_last));
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check_log("t1_beats", 32'h100);

        // Test 2: backpressure pattern 1-0-0-1
        run_frame(1, 1'b0, 1'b0);
        check_log("t2_beats", 32'h100);

        // Test 3: refill shadow and double commit while streaming
        cd_before = cd_count;
        run_frame(0, 1'b0, 1'b1);
        check_log("t3_cur_beats", 32'h100);
        check("t3_commit_pulses", 32'(cd_count - cd_before), 1);
        check("t3_bank", 32'(active_bank), 0);
        run_frame(0, 1'b0, 1'b0);
        check_log("t3_next_beats", 32'h200);

        // Test 4: out-of-range write, then start+commit together
        fill_shadow(32'h300);
        wr_en = 1'b1;
        wr_addr = AW'(NCH);
        wr_data = 24'hBADBAD;
        cycle();
        wr_en = 1'b0;
        run_frame(2, 1'b1, 1'b0);
        check_log("t4_beats", 32'h300);
        check("t4_bank", 32'(active_bank), 1);

        // Test 5: reset while beat 3 is presented, with a commit pending
        acc_log.delete();
        start = 1'b1;
        out_ready = 1'b1;
        cycle();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            commit = (i == 1);
            cycle();
            commit = 1'b0;
            found = out_valid && (out_addr == AW'(3));
        end
        check("t5_beat3_reached", 32'(found), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t5_valid_after_reset", 32'(out_valid), 0);
        check("t5_busy_after_reset", 32'(busy), 0);
        check("t5_bank_after_reset", 32'(active_bank), 0);
        cycle();
        cycle();
        check("t5_no_commit_done", 32'(commit_done), 0);
        run_frame(0, 1'b0, 1'b0);
        check_log("t5_beats", 32'h200);
        check("t5_bank_final", 32'(active_bank), 0);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            wr_en = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            commit = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        wr_en = 1'b0;
        commit = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && m_stream; i++) cycle();
        check("drain_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
